// File: rtl/gci_std_display_timing_generator_param.sv
// Parametrised display timing generator.
// The request stage walks (hc, vc) over the whole frame and issues pixel
// requests with coordinates. The display stage replays the decoded
// timing P_REQ_LEAD clocks later, which gives the VRAM read path time to
// prefetch. Enable/stop control always lets a started frame run to its end.
module gci_std_display_timing_generator_param #(
    parameter int P_H_ACTIVE  = 640,
    parameter int P_H_FRONT   = 16,
    parameter int P_H_SYNC    = 96,
    parameter int P_H_BACK    = 48,
    parameter int P_V_ACTIVE  = 480,
    parameter int P_V_FRONT   = 10,
    parameter int P_V_SYNC    = 2,
    parameter int P_V_BACK    = 33,
    parameter bit P_HSYNC_ACT = 1'b0,
    parameter bit P_VSYNC_ACT = 1'b0,
    parameter int P_REQ_LEAD  = 2,
    parameter int P_CNT_N     = 12
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iRESET_SYNC,
    input  logic               iENABLE,
    output logic               oDATA_REQ,
    output logic [P_CNT_N-1:0] oPIXEL_X,
    output logic [P_CNT_N-1:0] oPIXEL_Y,
    output logic               oDATA_SYNC,
    output logic               oFRAME_END,
    output logic               onDISP_RESET,
    output logic               oDISP_ENA,
    output logic               oDISP_BLANK,
    output logic               oDISP_HSYNC,
    output logic               oDISP_VSYNC
);

    typedef logic [P_CNT_N-1:0] cnt_t;

    localparam int H_TOTAL = P_H_ACTIVE + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int V_TOTAL = P_V_ACTIVE + P_V_FRONT + P_V_SYNC + P_V_BACK;

    // Region boundaries in counter order: active, front porch, sync, back porch.
    localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT_END  = cnt_t'(P_H_ACTIVE);
    localparam cnt_t V_ACT_END  = cnt_t'(P_V_ACTIVE);
    localparam cnt_t H_SYNC_BEG = cnt_t'(P_H_ACTIVE + P_H_FRONT);
    localparam cnt_t H_SYNC_END = cnt_t'(P_H_ACTIVE + P_H_FRONT + P_H_SYNC);
    localparam cnt_t V_SYNC_BEG = cnt_t'(P_V_ACTIVE + P_V_FRONT);
    localparam cnt_t V_SYNC_END = cnt_t'(P_V_ACTIVE + P_V_FRONT + P_V_SYNC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Decoded display-stage timing; flags are active-high internally and
    // mapped to the configured polarity only at the outputs.
    typedef struct packed {
        logic run;
        logic ena;
        logic hsync;
        logic vsync;
    } disp_t;

    state_t state, state_nxt;
    cnt_t   hc, vc, hc_nxt, vc_nxt;
    logic   running_nxt, wrap_nxt;
    logic   req_nxt, sync_nxt, frame_end_nxt, disp_rst_n_nxt;
    disp_t  disp_nxt;
    disp_t  pipe [0:P_REQ_LEAD];

    // Next-state, next-counter and next-output decode for the request stage.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        hc_nxt    = hc;
        vc_nxt    = vc;

        case (state)
            IDLE: begin
                // Counters stay at 0, so the first RUN cycle sits at (0, 0).
                if (iENABLE) state_nxt = RUN;
            end
            RUN, STOP: begin
                if (hc == H_LAST) begin
                    hc_nxt = '0;
                    vc_nxt = (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc_nxt = hc + 1'b1;
                end
                if (iENABLE)
                    state_nxt = RUN;
                else if (state == STOP && hc == H_LAST && vc == V_LAST)
                    state_nxt = IDLE;   // frame finished; counters wrapped to 0
                else
                    state_nxt = STOP;
            end
            default: begin
                state_nxt = IDLE;
                hc_nxt    = '0;
                vc_nxt    = '0;
            end
        endcase

        running_nxt   = (state_nxt != IDLE);
        wrap_nxt      = (hc_nxt == H_LAST) && (vc_nxt == V_LAST);
        req_nxt       = running_nxt && (hc_nxt < H_ACT_END) && (vc_nxt < V_ACT_END);
        sync_nxt      = (state_nxt == RUN) && wrap_nxt;
        frame_end_nxt = running_nxt && wrap_nxt;

        disp_nxt.run   = running_nxt;
        disp_nxt.ena   = req_nxt;
        disp_nxt.hsync = running_nxt && (hc_nxt >= H_SYNC_BEG) && (hc_nxt < H_SYNC_END);
        disp_nxt.vsync = running_nxt && (vc_nxt >= V_SYNC_BEG) && (vc_nxt < V_SYNC_END);

        // Display reset stays released while any running slot is still
        // inside the delay line, so it drops only once the line has flushed.
        disp_rst_n_nxt = disp_nxt.run;
        for (int i = 0; i < P_REQ_LEAD; i++)
            disp_rst_n_nxt = disp_rst_n_nxt | pipe[i].run;
    end

    // Request-stage state, counters and registered request outputs.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state      <= IDLE;
            hc         <= '0;
            vc         <= '0;
            oDATA_REQ  <= 1'b0;
            oDATA_SYNC <= 1'b0;
            oFRAME_END <= 1'b0;
        end else if (iRESET_SYNC) begin
            state      <= IDLE;
            hc         <= '0;
            vc         <= '0;
            oDATA_REQ  <= 1'b0;
            oDATA_SYNC <= 1'b0;
            oFRAME_END <= 1'b0;
        end else begin
            state      <= state_nxt;
            hc         <= hc_nxt;
            vc         <= vc_nxt;
            oDATA_REQ  <= req_nxt;
            oDATA_SYNC <= sync_nxt;
            oFRAME_END <= frame_end_nxt;
        end
    end

    assign oPIXEL_X = hc;
    assign oPIXEL_Y = vc;

    // Display-stage delay line: slot 0 aligns with the request stage,
    // slot P_REQ_LEAD drives the display outputs.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            // NOTE: the delay line is reset on purpose (it is small and must
            // start with idle timing), unlike a data RAM which is never reset.
            for (int i = 0; i <= P_REQ_LEAD; i++) pipe[i] <= '0;
            onDISP_RESET <= 1'b0;
        end else if (iRESET_SYNC) begin
            for (int i = 0; i <= P_REQ_LEAD; i++) pipe[i] <= '0;
            onDISP_RESET <= 1'b0;
        end else begin
            pipe[0] <= disp_nxt;
            for (int i = 1; i <= P_REQ_LEAD; i++) pipe[i] <= pipe[i-1];
            onDISP_RESET <= disp_rst_n_nxt;
        end
    end

    assign oDISP_ENA   = pipe[P_REQ_LEAD].ena;
    assign oDISP_BLANK = ~pipe[P_REQ_LEAD].ena;
    assign oDISP_HSYNC = pipe[P_REQ_LEAD].hsync ? P_HSYNC_ACT : ~P_HSYNC_ACT;
    assign oDISP_VSYNC = pipe[P_REQ_LEAD].vsync ? P_VSYNC_ACT : ~P_VSYNC_ACT;

endmodule

// File: tb/tb_gci_std_display_timing_generator_param.sv
// Directed bench for the parametrised display timing generator.
// Timing H = 4/1/2/1 (8 clocks/line), V = 3/1/1/1 (6 lines), 48 clocks/frame.
// Instance a: lead 2, active-low syncs. Instance b: lead 0, active-high hsync.
module tb_gci_std_display_timing_generator_param;

    localparam int CN = 12;

    logic          clk = 1'b0;
    logic          rst_n, rsync, en;

    logic          a_req, a_sync, a_fe, a_drst, a_ena, a_blank, a_hs, a_vs;
    logic [CN-1:0] a_x, a_y;
    logic          b_req, b_sync, b_fe, b_drst, b_ena, b_blank, b_hs, b_vs;
    logic [CN-1:0] b_x, b_y;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gci_std_display_timing_generator_param #(
        .P_H_ACTIVE(4), .P_H_FRONT(1), .P_H_SYNC(2), .P_H_BACK(1),
        .P_V_ACTIVE(3), .P_V_FRONT(1), .P_V_SYNC(1), .P_V_BACK(1),
        .P_HSYNC_ACT(1'b0), .P_VSYNC_ACT(1'b0), .P_REQ_LEAD(2), .P_CNT_N(CN)
    ) dut_a (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rsync), .iENABLE(en),
        .oDATA_REQ(a_req), .oPIXEL_X(a_x), .oPIXEL_Y(a_y),
        .oDATA_SYNC(a_sync), .oFRAME_END(a_fe), .onDISP_RESET(a_drst),
        .oDISP_ENA(a_ena), .oDISP_BLANK(a_blank),
        .oDISP_HSYNC(a_hs), .oDISP_VSYNC(a_vs)
    );

    gci_std_display_timing_generator_param #(
        .P_H_ACTIVE(4), .P_H_FRONT(1), .P_H_SYNC(2), .P_H_BACK(1),
        .P_V_ACTIVE(3), .P_V_FRONT(1), .P_V_SYNC(1), .P_V_BACK(1),
        .P_HSYNC_ACT(1'b1), .P_VSYNC_ACT(1'b0), .P_REQ_LEAD(0), .P_CNT_N(CN)
    ) dut_b (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rsync), .iENABLE(en),
        .oDATA_REQ(b_req), .oPIXEL_X(b_x), .oPIXEL_Y(b_y),
        .oDATA_SYNC(b_sync), .oFRAME_END(b_fe), .onDISP_RESET(b_drst),
        .oDISP_ENA(b_ena), .oDISP_BLANK(b_blank),
        .oDISP_HSYNC(b_hs), .oDISP_VSYNC(b_vs)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input logic [CN-1:0] obs, input logic [CN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check1({tag, "_a_req"},   a_req,   1'b0);
        checkn({tag, "_a_x"},     a_x,     '0);
        checkn({tag, "_a_y"},     a_y,     '0);
        check1({tag, "_a_sync"},  a_sync,  1'b0);
        check1({tag, "_a_fe"},    a_fe,    1'b0);
        check1({tag, "_a_drst"},  a_drst,  1'b0);
        check1({tag, "_a_ena"},   a_ena,   1'b0);
        check1({tag, "_a_blank"}, a_blank, 1'b1);
        check1({tag, "_a_hs"},    a_hs,    1'b1);
        check1({tag, "_a_vs"},    a_vs,    1'b1);
        check1({tag, "_b_req"},   b_req,   1'b0);
        check1({tag, "_b_drst"},  b_drst,  1'b0);
        check1({tag, "_b_ena"},   b_ena,   1'b0);
        check1({tag, "_b_blank"}, b_blank, 1'b1);
        check1({tag, "_b_hs"},    b_hs,    1'b0);
        check1({tag, "_b_vs"},    b_vs,    1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   f, hc, vc, p, phc, pvc, cnt_a, cnt_b, cnt_c;
        logic e_req, e_ena, e_hs, e_vs;

        // Power-on reset, then released with the generator disabled.
        rst_n = 1'b0; rsync = 1'b0; en = 1'b0;
        tick(); tick();
        check_reset("por");
        rst_n = 1'b1;
        repeat (3) tick();
        check_reset("idle_hold");

        // Two frames: the first fully enabled, the second stopped at line 1.
        en = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 96; k++) begin
            tick();
            f  = k % 48;
            hc = f % 8;
            vc = f / 8;
            e_req = (hc < 4) && (vc < 3);
            if (e_req) begin
                if (k < 48) cnt_a++; else cnt_b++;
            end
            if (k >= 2) begin
                p   = (k - 2) % 48;
                phc = p % 8;
                pvc = p / 8;
                e_ena = (phc < 4) && (pvc < 3);
                e_hs  = (phc == 5) || (phc == 6);
                e_vs  = (pvc == 4);
            end else begin
                e_ena = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
            end
            check1("run_a_req", a_req, e_req);
            if (e_req) begin
                checkn("run_a_x", a_x, CN'(hc));
                checkn("run_a_y", a_y, CN'(vc));
            end
            check1("run_a_sync",  a_sync,  (k == 47));
            check1("run_a_fe",    a_fe,    (k == 47) || (k == 95));
            check1("run_a_drst",  a_drst,  1'b1);
            check1("run_a_ena",   a_ena,   e_ena);
            check1("run_a_blank", a_blank, ~e_ena);
            check1("run_a_hs",    a_hs,    ~e_hs);
            check1("run_a_vs",    a_vs,    ~e_vs);
            check1("run_b_ena",   b_ena,   e_req);
            check1("run_b_hs",    b_hs,    (hc == 5) || (hc == 6));
            check1("run_b_vs",    b_vs,    ~(vc == 4));
            check1("run_b_drst",  b_drst,  1'b1);
            if (k == 56) en = 1'b0;
        end
        checki("reqs_frame_run",  cnt_a, 12);
        checki("reqs_frame_stop", cnt_b, 12);

        // First IDLE cycle after the stopped frame, then the display flush.
        tick();
        check1("idle0_a_req",  a_req,  1'b0);
        checkn("idle0_a_x",    a_x,    '0);
        checkn("idle0_a_y",    a_y,    '0);
        check1("idle0_a_sync", a_sync, 1'b0);
        check1("idle0_a_fe",   a_fe,   1'b0);
        check1("idle0_a_drst", a_drst, 1'b1);
        check1("idle0_a_hs",   a_hs,   1'b0);
        check1("idle0_a_ena",  a_ena,  1'b0);
        check1("idle0_b_drst", b_drst, 1'b0);
        check1("idle0_b_hs",   b_hs,   1'b0);
        tick();
        check1("idle1_a_drst", a_drst, 1'b1);
        check1("idle1_a_hs",   a_hs,   1'b1);
        tick();
        check1("idle2_a_drst",  a_drst,  1'b0);
        check1("idle2_a_blank", a_blank, 1'b1);
        check1("idle2_a_vs",    a_vs,    1'b1);

        // Stop at line 1, resume before the wrap: next frame follows seamlessly.
        en = 1'b1;
        cnt_c = 0;
        for (int k = 0; k <= 48; k++) begin
            tick();
            f  = k % 48;
            hc = f % 8;
            vc = f / 8;
            e_req = (hc < 4) && (vc < 3);
            if (e_req && k < 48) cnt_c++;
            check1("resume_a_req",  a_req,  e_req);
            check1("resume_a_sync", a_sync, (k == 47));
            check1("resume_a_fe",   a_fe,   (k == 47));
            check1("resume_a_drst", a_drst, 1'b1);
            if (k == 8)  en = 1'b0;
            if (k == 20) en = 1'b1;
        end
        checki("reqs_frame_resume", cnt_c, 12);
        checkn("resume_next_x", a_x, '0);
        checkn("resume_next_y", a_y, '0);

        // Asynchronous reset mid-line takes effect without a clock edge.
        repeat (3) tick();
        checkn("pre_async_x", a_x, CN'(3));
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        check_reset("post_async");

        // Synchronous clear mid-line, with enable still high.
        en = 1'b1;
        tick();
        check1("restart_a_req", a_req, 1'b1);
        checkn("restart_a_x",   a_x,   '0);
        checkn("restart_a_y",   a_y,   '0);
        repeat (10) tick();
        checkn("mid_a_x", a_x, CN'(2));
        checkn("mid_a_y", a_y, CN'(1));
        check1("mid_b_hs_off", b_hs, 1'b0);
        repeat (3) tick();
        checkn("hs_a_x", a_x, CN'(5));
        check1("hs_b_on",  b_hs, 1'b1);
        check1("hs_a_off", a_hs, 1'b1);
        rsync = 1'b1;
        tick();
        check_reset("sync_rst");
        tick();
        check_reset("sync_rst_hold");
        rsync = 1'b0;
        en    = 1'b0;
        tick();
        check_reset("sync_rst_rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
